// File: rtl/mrd_rdx2345_if.sv
// Stage-input bundle of the radix-2/3/4/5 DFT + twiddle stage.
// The read sequencer drives it and the butterfly datapath consumes it.
interface mrd_rdx2345_if #(
    parameter int W = 30
);
    logic              valid;
    logic [4:0][W-1:0] d_real;
    logic [4:0][W-1:0] d_imag;
    logic [4:0][2:0]   bank_index;
    logic [4:0][7:0]   bank_addr;
    logic [2:0]        factor;
    logic [11:0]       twdl_numrtr;
    logic [11:0]       twdl_demontr;

    modport master (
        output valid, d_real, d_imag, bank_index, bank_addr,
        output factor, twdl_numrtr, twdl_demontr
    );
    modport slave (
        input valid, d_real, d_imag, bank_index, bank_addr,
        input factor, twdl_numrtr, twdl_demontr
    );
endinterface

// File: rtl/mrd_rdx2345_rd_seq.sv
// Read-side sequencer: walks the butterflies of one DFT stage, reads the
// five banks and realigns the returned words into element order.
module mrd_rdx2345_rd_seq #(
    parameter int wDataInOut = 30,
    parameter int RD_LAT     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [2:0]                 cfg_factor,
    input  logic [8:0]                 cfg_num_bfly,
    input  logic [11:0]                cfg_twdl_demontr,
    input  logic                       hold,
    output logic                       busy,
    output logic                       done,
    output logic [4:0]                 rd_en,
    output logic [4:0][7:0]            rd_addr,
    input  logic [4:0][wDataInOut-1:0] rd_real,
    input  logic [4:0][wDataInOut-1:0] rd_imag,
    mrd_rdx2345_if.master              out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef struct packed {
        logic            vld;
        logic            last;
        logic [4:0][2:0] bidx;
        logic [7:0]      addr;
        logic [11:0]     num;
    } tag_t;

    logic [1:0]  state;
    logic [8:0]  j;
    logic [2:0]  rot;
    logic [11:0] num;
    logic [2:0]  fac;
    logic [8:0]  nbfly;
    logic [11:0] den;
    logic [7:0]  last_addr;
    tag_t        sr [RD_LAT];
    tag_t        push;
    tag_t        al;

    logic        issue;
    logic        accept;
    logic        zero_go;
    logic        is_last;
    logic [11:0] den_eff;
    logic [11:0] num_nxt;

    function automatic logic [2:0] rot_add(input logic [2:0] r, input int m);
        logic [3:0] s;
        s = {1'b0, r} + 4'(m);
        if (s >= 4'd5) s = s - 4'd5;
        return s[2:0];
    endfunction

    assign issue   = (state == S_RUN) && !hold;
    // A start landing on the done cycle belongs to the finishing stage.
    assign accept  = (state == S_IDLE) && start && !done;
    assign zero_go = accept && (cfg_num_bfly == 9'd0);
    assign is_last = (j == nbfly - 9'd1);
    assign den_eff = (den == 12'd0) ? 12'd1 : den;
    assign num_nxt = (num + 12'd1 == den_eff) ? 12'd0 : num + 12'd1;
    assign busy    = (state != S_IDLE);
    assign al      = sr[RD_LAT-1];

    always_comb begin
        push      = '0;
        push.vld  = issue;
        push.last = is_last;
        push.addr = j[7:0];
        push.num  = num;
        for (int m = 0; m < 5; m++) push.bidx[m] = rot_add(rot, m);
    end

    always_comb begin
        rd_en = {5{issue}};
        for (int b = 0; b < 5; b++) rd_addr[b] = issue ? j[7:0] : last_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            j         <= '0;
            rot       <= '0;
            num       <= '0;
            fac       <= '0;
            nbfly     <= '0;
            den       <= '0;
            last_addr <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    fac   <= cfg_factor;
                    nbfly <= cfg_num_bfly;
                    den   <= cfg_twdl_demontr;
                    j     <= '0;
                    rot   <= '0;
                    num   <= '0;
                    if (cfg_num_bfly != 9'd0) state <= S_RUN;
                end
                S_RUN: if (!hold) begin
                    last_addr <= j[7:0];
                    j         <= j + 9'd1;
                    rot       <= (rot == 3'd4) ? 3'd0 : rot + 3'd1;
                    num       <= num_nxt;
                    if (is_last) state <= S_DRAIN;
                end
                S_DRAIN: if (done) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) sr[i] <= '0;
        end else begin
            sr[0] <= push;
            for (int i = 1; i < RD_LAT; i++) sr[i] <= sr[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done             <= 1'b0;
            out.valid        <= 1'b0;
            out.d_real       <= '0;
            out.d_imag       <= '0;
            out.bank_index   <= '0;
            out.bank_addr    <= '0;
            out.factor       <= '0;
            out.twdl_numrtr  <= '0;
            out.twdl_demontr <= '0;
        end else begin
            done      <= (al.vld && al.last) || zero_go;
            out.valid <= al.vld;
            if (al.vld) begin
                for (int m = 0; m < 5; m++) begin
                    out.d_real[m]    <= (3'(m) < fac) ? rd_real[al.bidx[m]] : '0;
                    out.d_imag[m]    <= (3'(m) < fac) ? rd_imag[al.bidx[m]] : '0;
                    out.bank_addr[m] <= al.addr;
                end
                out.bank_index   <= al.bidx;
                out.factor       <= fac;
                out.twdl_numrtr  <= al.num;
                out.twdl_demontr <= den;
            end
        end
    end

endmodule

// File: tb/tb_mrd_rdx2345_rd_seq.sv
// Bench for mrd_rdx2345_rd_seq: three instances (RD_LAT 1..3) share
// stimulus and are traced against a cycle-level reference model.
module tb_mrd_rdx2345_rd_seq;
    localparam int W  = 30;
    localparam int NC = 340;

    typedef struct packed {
        logic [4:0][2:0]   bi;
        logic [4:0][7:0]   ba;
        logic [4:0][W-1:0] re;
        logic [4:0][W-1:0] im;
        logic [11:0]       nu;
        logic [11:0]       de;
        logic [2:0]        fa;
    } beat_t;

    typedef struct packed {
        logic            v;
        logic            d;
        logic            b;
        logic [4:0]      en;
        logic [4:0][7:0] a;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic [2:0]  cfg_factor = '0;
    logic [8:0]  cfg_num_bfly = '0;
    logic [11:0] cfg_twdl_demontr = '0;

    always #5 clk = ~clk;

    logic [W-1:0] mem_r [5][256];
    logic [W-1:0] mem_i [5][256];

    logic            ov  [3];
    logic            od  [3];
    logic            ob  [3];
    logic [4:0]      oen [3];
    logic [4:0][7:0] oadr[3];
    beat_t           obt [3];

    ctl_t  cc [3][NC];
    ctl_t  ec [3][NC];
    beat_t cb [3][NC];
    beat_t eb [3][NC];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int L = g + 1;
        logic [4:0][W-1:0] rr;
        logic [4:0][W-1:0] ri;
        logic [4:0][7:0]   ap [L];

        mrd_rdx2345_if #(.W(W)) ifc ();

        mrd_rdx2345_rd_seq #(.wDataInOut(W), .RD_LAT(L)) dut (
            .clk              (clk),
            .rst              (rst),
            .start            (start),
            .cfg_factor       (cfg_factor),
            .cfg_num_bfly     (cfg_num_bfly),
            .cfg_twdl_demontr (cfg_twdl_demontr),
            .hold             (hold),
            .busy             (ob[g]),
            .done             (od[g]),
            .rd_en            (oen[g]),
            .rd_addr          (oadr[g]),
            .rd_real          (rr),
            .rd_imag          (ri),
            .out              (ifc)
        );

        // bank model: address registered, word visible L cycles later
        always @(posedge clk) begin
            ap[0] <= oadr[g];
            for (int i = 1; i < L; i++) ap[i] <= ap[i-1];
        end

        always_comb begin
            for (int b = 0; b < 5; b++) begin
                rr[b] = mem_r[b][ap[L-1][b]];
                ri[b] = mem_i[b][ap[L-1][b]];
            end
        end

        assign ov[g]  = ifc.valid;
        assign obt[g] = {ifc.bank_index, ifc.bank_addr, ifc.d_real,
                         ifc.d_imag, ifc.twdl_numrtr, ifc.twdl_demontr,
                         ifc.factor};
    end

    task automatic fill_mem(input bit rnd);
        for (int b = 0; b < 5; b++)
            for (int a = 0; a < 256; a++) begin
                mem_r[b][a] = rnd ? W'($urandom) : W'(b * 256 + a);
                mem_i[b][a] = rnd ? W'($urandom) : W'(a * 256 + b);
            end
    endtask

    task automatic capture(input int c);
        for (int k = 0; k < 3; k++) begin
            cc[k][c].v  = ov[k];
            cc[k][c].d  = od[k];
            cc[k][c].b  = ob[k];
            cc[k][c].en = oen[k];
            cc[k][c].a  = (oen[k] != 5'd0) ? oadr[k] : '0;
            cb[k][c]    = ov[k] ? obt[k] : '0;
        end
    endtask

    // cycle 0 is the cycle in which start is high
    task automatic run_stage(input logic [2:0] f, input logic [8:0] n,
                             input logic [11:0] d, input logic [63:0] hm,
                             input logic [63:0] sm, input logic [8:0] n2,
                             input int nc);
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_factor = f;
        cfg_num_bfly = n;
        cfg_twdl_demontr = d;
        hold = hm[0];
        for (int c = 0; c < nc; c++) begin
            @(negedge clk);
            capture(c);
            @(posedge clk);
            #1;
            cfg_num_bfly = n2;
            start = (c + 1 < 64) ? sm[c+1] : 1'b0;
            hold  = (c + 1 < 64) ? hm[c+1] : 1'b0;
        end
        start = 1'b0;
        hold = 1'b0;
    endtask

    // reference: issue j on every non-held cycle from 1, beat after L+1
    task automatic model_stage(input int f, input int n, input int d,
                               input logic [63:0] hm);
        int c, j, t, dd;
        int last [3];
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NC; i++) begin
                ec[k][i] = '0;
                eb[k][i] = '0;
            end
        dd = (d == 0) ? 1 : d;
        c = 1;
        j = 0;
        while (j < n) begin
            if (!(c < 64 && hm[c])) begin
                for (int k = 0; k < 3; k++) begin
                    t = c + k + 2;
                    ec[k][c].en = 5'h1f;
                    ec[k][c].a  = {5{8'(j)}};
                    ec[k][t].v  = 1'b1;
                    for (int m = 0; m < 5; m++) begin
                        eb[k][t].bi[m] = 3'((j + m) % 5);
                        eb[k][t].ba[m] = 8'(j);
                        eb[k][t].re[m] = (m < f) ? mem_r[(j+m)%5][j] : '0;
                        eb[k][t].im[m] = (m < f) ? mem_i[(j+m)%5][j] : '0;
                    end
                    eb[k][t].nu = 12'(j % dd);
                    eb[k][t].de = 12'(d);
                    eb[k][t].fa = 3'(f);
                    last[k] = t;
                end
                j++;
            end
            c++;
        end
        for (int k = 0; k < 3; k++) begin
            if (n == 0) ec[k][1].d = 1'b1;
            else begin
                ec[k][last[k]].d = 1'b1;
                for (int i = 1; i <= last[k]; i++) ec[k][i].b = 1'b1;
            end
        end
    endtask

    task automatic test_stage(input string name, input int f, input int n,
                              input int d, input logic [63:0] hm,
                              input logic [63:0] sm, input int n2,
                              input bit rnd);
        int nc;
        nc = n + 80;
        fill_mem(rnd);
        model_stage(f, n, d, hm);
        run_stage(3'(f), 9'(n), 12'(d), hm, sm, 9'(n2), nc);
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < nc; c++) begin
                n_cmp++;
                if (cc[k][c] !== ec[k][c]) begin
                    n_bad++;
                    $display("FAIL %s ctl lat%0d cyc%0d got %h want %h",
                             name, k + 1, c, cc[k][c], ec[k][c]);
                end
                if (ec[k][c].v) begin
                    n_cmp++;
                    if (cb[k][c] !== eb[k][c]) begin
                        n_bad++;
                        $display("FAIL %s beat lat%0d cyc%0d got %h want %h",
                                 name, k + 1, c, cb[k][c], eb[k][c]);
                    end
                end
            end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({ob[k], od[k], oen[k], oadr[k], ov[k], obt[k]} !== '0) begin
                n_bad++;
                $display("FAIL reset_state lat%0d got nonzero outputs", k + 1);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_radix4();
        logic [15:0] vm, dm;
        test_stage("radix4", 4, 4, 4, '0, '0, 4, 1'b0);
        for (int c = 0; c < 16; c++) begin
            vm[c] = cc[0][c].v;
            dm[c] = cc[0][c].d;
        end
        n_cmp += 5;
        if (vm !== 16'h0078) begin
            n_bad++;
            $display("FAIL r4_valid_cycles got %h want 0078", vm);
        end
        if (dm !== 16'h0040) begin
            n_bad++;
            $display("FAIL r4_done_cycle got %h want 0040", dm);
        end
        if (cb[0][4].bi !== {3'd0, 3'd4, 3'd3, 3'd2, 3'd1}) begin
            n_bad++;
            $display("FAIL r4_bank_index got %h", cb[0][4].bi);
        end
        if (cb[0][4].nu !== 12'd1 || cb[0][4].re[4] !== '0) begin
            n_bad++;
            $display("FAIL r4_beat1 nu %0d re4 %0d want 1 0",
                     cb[0][4].nu, cb[0][4].re[4]);
        end
        if (cb[0][4].re[0] !== W'(257) || cb[0][4].re[3] !== W'(1025)) begin
            n_bad++;
            $display("FAIL r4_data re0 %0d re3 %0d want 257 1025",
                     cb[0][4].re[0], cb[0][4].re[3]);
        end
    endtask

    task automatic test_radix5_full();
        int cnt;
        logic [3:0][11:0] ns;
        test_stage("radix5_256", 5, 256, 3, '0, '0, 256, 1'b1);
        cnt = 0;
        ns = '0;
        for (int c = 0; c < NC - 4; c++)
            if (cc[0][c].v) begin
                if (cnt < 4) ns[cnt] = cb[0][c].nu;
                cnt++;
            end
        n_cmp += 3;
        if (cnt != 256) begin
            n_bad++;
            $display("FAIL r5_count got %0d want 256", cnt);
        end
        if (ns !== {12'd0, 12'd2, 12'd1, 12'd0}) begin
            n_bad++;
            $display("FAIL r5_numrtr_seq got %h", ns);
        end
        if (cb[0][258].ba[0] !== 8'd255 || cb[0][258].nu !== 12'd0) begin
            n_bad++;
            $display("FAIL r5_last addr %0d nu %0d want 255 0",
                     cb[0][258].ba[0], cb[0][258].nu);
        end
    endtask

    task automatic test_lat3();
        int first;
        test_stage("lat3_r3", 3, 5, 2, '0, '0, 5, 1'b1);
        first = -1;
        for (int c = 0; c < 20; c++)
            if (cc[2][c].v && first < 0) first = c;
        n_cmp += 2;
        if (first != 5) begin
            n_bad++;
            $display("FAIL lat3_first_valid got %0d want 5", first);
        end
        if (cb[2][7].re[0] !== mem_r[2][2] || cb[2][7].re[2] !== mem_r[4][2]
            || cb[2][7].re[3] !== '0 || cb[2][7].re[4] !== '0) begin
            n_bad++;
            $display("FAIL lat3_beat2 got %h", cb[2][7].re);
        end
    endtask

    task automatic test_hold();
        logic [15:0] vm;
        logic [5:0][7:0] seq;
        int cnt;
        test_stage("hold_r2", 2, 6, 2, 64'h1c, '0, 6, 1'b1);
        cnt = 0;
        seq = '0;
        for (int c = 0; c < 40; c++) begin
            if (c < 16) vm[c] = cc[0][c].v;
            if (cc[0][c].v) begin
                if (cnt < 6) seq[cnt] = cb[0][c].ba[0];
                cnt++;
            end
        end
        n_cmp += 2;
        if (vm !== 16'h0f88) begin
            n_bad++;
            $display("FAIL hold_gap got %h want 0f88", vm);
        end
        if (cnt != 6 || seq !== {8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}) begin
            n_bad++;
            $display("FAIL hold_order cnt %0d seq %h", cnt, seq);
        end
    endtask

    task automatic test_zero_bfly();
        int nv, ne, nb;
        logic [7:0] dm;
        test_stage("zero", 3, 0, 5, '0, '0, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            nv = 0;
            ne = 0;
            nb = 0;
            for (int c = 0; c < 80; c++) begin
                if (c < 8) dm[c] = cc[k][c].d;
                nv += int'(cc[k][c].v);
                nb += int'(cc[k][c].b);
                ne += int'(cc[k][c].en != 5'd0);
            end
            n_cmp++;
            if (dm !== 8'h02 || nv != 0 || ne != 0 || nb != 0) begin
                n_bad++;
                $display("FAIL zero_bfly lat%0d done %h v %0d en %0d busy %0d",
                         k + 1, dm, nv, ne, nb);
            end
        end
    endtask

    task automatic test_busy_start();
        int cnt;
        test_stage("busy_start", 2, 8, 5, '0, 64'h408, 3, 1'b1);
        cnt = 0;
        for (int c = 0; c < 88; c++) cnt += int'(cc[0][c].v);
        n_cmp++;
        if (cnt != 8) begin
            n_bad++;
            $display("FAIL busy_start_count got %0d want 8", cnt);
        end
    endtask

    task automatic test_mid_reset();
        int nv;
        fill_mem(1'b1);
        @(posedge clk);
        #1;
        cfg_factor = 3'd5;
        cfg_num_bfly = 9'd40;
        cfg_twdl_demontr = 12'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (oadr[1][0] !== 8'd10 || oen[1] !== 5'h1f) begin
            n_bad++;
            $display("FAIL mid_reset_pre addr %0d en %h want 10 1f",
                     oadr[1][0], oen[1]);
        end
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({ob[k], od[k], oen[k], oadr[k], ov[k], obt[k]} !== '0) begin
                n_bad++;
                $display("FAIL mid_reset_zero lat%0d outputs nonzero", k + 1);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        nv = 0;
        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) nv += int'(ov[k]) + int'(ob[k]);
        end
        n_cmp++;
        if (nv != 0) begin
            n_bad++;
            $display("FAIL mid_reset_stale got %0d want 0", nv);
        end
        test_stage("after_reset", 2, 3, 2, '0, '0, 3, 1'b1);
    endtask

    task automatic test_random();
        int f, n, d;
        logic [63:0] hm;
        for (int it = 0; it < 6; it++) begin
            f = $urandom_range(2, 5);
            n = (it == 0) ? 0 : $urandom_range(1, 40);
            d = $urandom_range(0, 7);
            hm = {$urandom, $urandom};
            test_stage("random", f, n, d, hm, '0, n, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_radix4();
        test_radix5_full();
        test_lat3();
        test_hold();
        test_zero_bfly();
        test_busy_start();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
